// File: rtl/bus_bridge_slave.sv
// bus_bridge_slave
// Collects a serial bus request (address, then write data, LSB first), ships
// it to a remote bridge as one UART frame {mode, data, addr}, and for reads
// waits for the returned byte and shifts it back out on srdata.
module bus_bridge_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    localparam int FRAME_WIDTH = 1 + DATA_WIDTH + ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   swdata,
    input  logic                   smode,
    input  logic                   mvalid,
    output logic                   srdata,
    output logic                   svalid,
    output logic                   sready,
    output logic [FRAME_WIDTH-1:0] u_din,
    output logic                   u_en,
    input  logic                   u_tx_busy,
    input  logic                   u_rx_ready,
    input  logic [DATA_WIDTH-1:0]  u_dout
);

    localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(MAX_WIDTH);
    localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDR_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        SEND,
        WAIT_RX,
        RDATA
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_WIDTH-1:0]     count;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic                     mode;
    logic [DATA_WIDTH-1:0]    shift;
    logic                     prev_rx_ready;
    logic [FRAME_WIDTH-1:0]   din_q;

    logic                     rx_rise;
    logic                     tx_fire;
    logic [FRAME_WIDTH-1:0]   frame;

    assign rx_rise = u_rx_ready & ~prev_rx_ready;
    assign tx_fire = (state == SEND) && !u_tx_busy;
    assign frame   = {mode, data, addr};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default assignment first keeps this block latch-free even
        // on paths that do not change state.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mvalid) state_nxt = ADDR;
            end
            ADDR: begin
                if (mvalid && count == ADDR_LAST) state_nxt = mode ? WDATA : SEND;
            end
            WDATA: begin
                if (mvalid && count == DATA_LAST) state_nxt = SEND;
            end
            SEND: begin
                if (!u_tx_busy) state_nxt = mode ? IDLE : WAIT_RX;
            end
            WAIT_RX: begin
                if (rx_rise) state_nxt = RDATA;
            end
            RDATA: begin
                if (count == DATA_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: bit collection, frame hold register, read-back shifter.
    // Address and data are shifted in from the MSB end, so once a field has
    // received all of its bits the first (LSB) bit sits at index 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count         <= '0;
            addr          <= '0;
            data          <= '0;
            mode          <= 1'b0;
            shift         <= '0;
            prev_rx_ready <= 1'b0;
            din_q         <= '0;
        end else begin
            prev_rx_ready <= u_rx_ready;
            case (state)
                IDLE: begin
                    if (mvalid) begin
                        addr  <= {swdata, addr[ADDR_WIDTH-1:1]};
                        mode  <= smode;
                        count <= CNT_WIDTH'(1);
                    end
                end
                ADDR: begin
                    if (mvalid) begin
                        addr <= {swdata, addr[ADDR_WIDTH-1:1]};
                        if (count == ADDR_LAST) begin
                            count <= '0;
                            // Reads carry an all-zero data field in the frame.
                            if (!mode) data <= '0;
                        end else begin
                            count <= count + CNT_WIDTH'(1);
                        end
                    end
                end
                WDATA: begin
                    if (mvalid) begin
                        data <= {swdata, data[DATA_WIDTH-1:1]};
                        if (count == DATA_LAST) count <= '0;
                        else                    count <= count + CNT_WIDTH'(1);
                    end
                end
                SEND: begin
                    if (!u_tx_busy) din_q <= frame;
                end
                WAIT_RX: begin
                    if (rx_rise) begin
                        shift <= u_dout;
                        count <= '0;
                    end
                end
                RDATA: begin
                    shift <= shift >> 1;
                    if (count == DATA_LAST) count <= '0;
                    else                    count <= count + CNT_WIDTH'(1);
                end
                default: count <= '0;
            endcase
        end
    end

    // Output decode; u_din shows the frame in the strobe cycle, then holds it.
    always_comb begin
        sready = (state == IDLE);
        u_en   = tx_fire;
        u_din  = tx_fire ? frame : din_q;
        svalid = (state == RDATA);
        srdata = (state == RDATA) & shift[0];
    end

endmodule

// File: tb/tb_bus_bridge_slave.sv
// Self-checking bench for bus_bridge_slave: expected UART frames and read-back
// bits are queued as stimulus is driven and compared as the DUT emits them.
module tb_bus_bridge_slave;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int FW = 1 + DW + AW;

    logic          clk;
    logic          rstn;
    logic          swdata;
    logic          smode;
    logic          mvalid;
    logic          srdata;
    logic          svalid;
    logic          sready;
    logic [FW-1:0] u_din;
    logic          u_en;
    logic          u_tx_busy;
    logic          u_rx_ready;
    logic [DW-1:0] u_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int en_count = 0;
    int sv_count = 0;
    int run      = 0;
    int last_run = 0;

    logic [31:0] exp_frames[$];
    logic        exp_bits[$];

    bus_bridge_slave #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .swdata     (swdata),
        .smode      (smode),
        .mvalid     (mvalid),
        .srdata     (srdata),
        .svalid     (svalid),
        .sready     (sready),
        .u_din      (u_din),
        .u_en       (u_en),
        .u_tx_busy  (u_tx_busy),
        .u_rx_ready (u_rx_ready),
        .u_dout     (u_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rstn) begin
            run = 0;
        end else begin
            if (u_en) begin
                en_count++;
                if (exp_frames.size() == 0) check("u_en_unexpected", 32'(u_en), 32'd0);
                else                        check("u_din_frame", 32'(u_din), exp_frames.pop_front());
            end
            if (svalid) begin
                sv_count++;
                run++;
                if (exp_bits.size() == 0) check("svalid_unexpected", 32'(svalid), 32'd0);
                else                      check("srdata_bit", 32'(srdata), 32'(exp_bits.pop_front()));
            end else if (run != 0) begin
                last_run = run;
                run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte_bits(input logic [DW-1:0] b, input int n);
        for (int i = 0; i < n; i++) exp_bits.push_back(b[i]);
    endtask

    // Shift one request onto the bus. Returns just after the edge that
    // captured the final bit, i.e. with the DUT sitting in SEND.
    task automatic bus_txn(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int stall_at, input int stall_len);
        int guard = 0;
        logic [FW-1:0] f;
        while (!sready && guard < 50) begin
            tick();
            guard++;
        end
        check("sready_before_txn", 32'(sready), 32'd1);
        f = {m, (m ? d : {DW{1'b0}}), a};
        exp_frames.push_back(32'(f));
        for (int i = 0; i < AW; i++) begin
            mvalid = 1'b1;
            swdata = a[i];
            smode  = (i == 0) ? m : ~m;
            tick();
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    mvalid = 1'b0;
                    swdata = ~swdata;
                    sample();
                    check("sready_stall", 32'(sready), 32'd0);
                    tick();
                end
            end
        end
        if (m) begin
            for (int i = 0; i < DW; i++) begin
                mvalid = 1'b1;
                swdata = d[i];
                smode  = 1'b0;
                tick();
            end
        end
        mvalid = 1'b0;
        swdata = 1'b0;
        smode  = 1'b0;
    endtask

    task automatic wait_read_done(input int n_bits, input string tag);
        int start = sv_count;
        int guard = 0;
        while (sv_count < start + n_bits && guard < 40) begin
            sample();
            guard++;
        end
        check({tag, "_bits"}, 32'(sv_count - start), 32'(n_bits));
    endtask

    initial begin
        int en_snap;
        int sv_snap;
        int guard;

        rstn       = 1'b0;
        swdata     = 1'b0;
        smode      = 1'b0;
        mvalid     = 1'b0;
        u_tx_busy  = 1'b0;
        u_rx_ready = 1'b0;
        u_dout     = '0;

        // Reset state.
        sample();
        check("rst_u_din", 32'(u_din), 32'd0);
        check("rst_u_en", 32'(u_en), 32'd0);
        check("rst_svalid", 32'(svalid), 32'd0);
        check("rst_srdata", 32'(srdata), 32'd0);
        tick();
        rstn = 1'b1;
        sample();
        check("rst_sready", 32'(sready), 32'd1);
        tick();

        // Write: addr 0x0A5, data 0x3C.
        bus_txn(1'b1, 12'h0A5, 8'h3C, -1, 0);
        sample();
        check("wr_u_en", 32'(u_en), 32'd1);
        check("wr_u_din", 32'(u_din), 32'h13C0A5);
        check("wr_sready_send", 32'(sready), 32'd0);
        tick();
        sample();
        check("wr_u_en_single", 32'(u_en), 32'd0);
        check("wr_sready_after", 32'(sready), 32'd1);
        check("wr_u_din_hold", 32'(u_din), 32'h13C0A5);
        tick();

        // Read: addr 0x123, returned byte 0x5A.
        bus_txn(1'b0, 12'h123, 8'hEE, -1, 0);
        sample();
        check("rd_u_en", 32'(u_en), 32'd1);
        check("rd_u_din", 32'(u_din), 32'h000123);
        tick();
        sample();
        check("rd_wait_svalid", 32'(svalid), 32'd0);
        check("rd_wait_sready", 32'(sready), 32'd0);
        tick();
        u_dout     = 8'h5A;
        u_rx_ready = 1'b1;
        exp_bits.push_back(1'b0); exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0); exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1); exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1); exp_bits.push_back(1'b0);
        wait_read_done(8, "rd1");
        tick();
        sample();
        check("rd1_run_len", 32'(last_run), 32'd8);
        check("rd1_svalid_end", 32'(svalid), 32'd0);
        check("rd1_srdata_end", 32'(srdata), 32'd0);
        check("rd1_sready_end", 32'(sready), 32'd1);
        tick();
        u_rx_ready = 1'b0;

        // Stall for 3 cycles after address bit 5.
        bus_txn(1'b1, 12'h2C7, 8'h91, 5, 3);
        sample();
        check("stall_u_en", 32'(u_en), 32'd1);
        check("stall_u_din", 32'(u_din), 32'h1912C7);
        tick();

        // TX backpressure: busy for 10 cycles in SEND.
        u_tx_busy = 1'b1;
        bus_txn(1'b1, 12'hF0F, 8'hA5, -1, 0);
        for (int c = 0; c < 10; c++) begin
            sample();
            check("bp_u_en_low", 32'(u_en), 32'd0);
            check("bp_sready_low", 32'(sready), 32'd0);
            if (c == 9) check("bp_u_din_held", 32'(u_din), 32'h1912C7);
            tick();
        end
        u_tx_busy = 1'b0;
        sample();
        check("bp_u_en", 32'(u_en), 32'd1);
        check("bp_u_din", 32'(u_din), 32'h1A5F0F);
        tick();
        sample();
        check("bp_u_en_single", 32'(u_en), 32'd0);
        tick();

        // Spurious RX rising edge while idle is dropped.
        u_dout     = 8'hFF;
        u_rx_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            check("spur_svalid", 32'(svalid), 32'd0);
            tick();
        end
        u_rx_ready = 1'b0;
        tick();
        bus_txn(1'b0, 12'h3FE, 8'h77, -1, 0);
        sample();
        check("rd2_u_din", 32'(u_din), 32'h0003FE);
        tick();
        u_dout     = 8'hC3;
        u_rx_ready = 1'b1;
        push_byte_bits(8'hC3, DW);
        wait_read_done(8, "rd2");
        tick();
        sample();
        check("rd2_run_len", 32'(last_run), 32'd8);
        tick();
        u_rx_ready = 1'b0;
        tick();

        // Reset in the middle of RDATA, after 3 bits.
        bus_txn(1'b0, 12'h055, 8'h00, -1, 0);
        sample();
        check("rd3_u_din", 32'(u_din), 32'h000055);
        tick();
        u_dout     = 8'hA7;
        u_rx_ready = 1'b1;
        push_byte_bits(8'hA7, 3);
        sv_snap = sv_count;
        guard = 0;
        while (sv_count < sv_snap + 3 && guard < 20) begin
            sample();
            guard++;
        end
        check("mid_rd_bits", 32'(sv_count - sv_snap), 32'd3);
        rstn = 1'b0;
        #1;
        check("mid_rst_svalid", 32'(svalid), 32'd0);
        check("mid_rst_srdata", 32'(srdata), 32'd0);
        check("mid_rst_u_en", 32'(u_en), 32'd0);
        check("mid_rst_u_din", 32'(u_din), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        en_snap = en_count;
        sv_snap = sv_count;
        sample();
        check("post_rst_sready", 32'(sready), 32'd1);
        for (int c = 0; c < 12; c++) begin
            sample();
            check("post_rst_svalid", 32'(svalid), 32'd0);
            check("post_rst_u_en", 32'(u_en), 32'd0);
        end
        check("post_rst_no_bits", 32'(sv_count - sv_snap), 32'd0);
        check("post_rst_no_frames", 32'(en_count - en_snap), 32'd0);
        u_rx_ready = 1'b0;

        check("sb_frames_left", 32'(exp_frames.size()), 32'd0);
        check("sb_bits_left", 32'(exp_bits.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_bridge_slave.md
BUS_BRIDGE_SLAVE -- requirements
Module: bus_bridge_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: slave-side memory address bits carried on the serial bus and in the UART frame.
REQ-002 Parameter DATA_WIDTH, default 8: data word width.
REQ-003 Derived FRAME_WIDTH = 1 + DATA_WIDTH + ADDR_WIDTH: UART TX frame, packed {mode, data, addr}.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 swdata  in  1  serial write bits: address, then data, each LSB first.
REQ-007 smode  in  1  0 = read, 1 = write; sampled with the first address bit.
REQ-008 mvalid  in  1  qualifies swdata and smode for the current cycle.
REQ-009 srdata  out  1  serial read-data bit, LSB first.
REQ-010 svalid  out  1  qualifies srdata.
REQ-011 sready  out  1  high only when idle and able to accept a new transaction.
REQ-012 u_din  out  FRAME_WIDTH  frame presented to the UART transmitter.
REQ-013 u_en  out  1  one-cycle transmit strobe.
REQ-014 u_tx_busy  in  1  UART transmitter busy.
REQ-015 u_rx_ready  in  1  UART receive-complete level; a rising edge marks new u_dout.
REQ-016 u_dout  in  DATA_WIDTH  read data returned by the remote bridge.

Function
REQ-017 FSM states SHALL be IDLE, ADDR, WDATA, SEND, WAIT_RX, RDATA.
REQ-018 IDLE: sready=1. With mvalid=1, capture swdata as addr[0] and smode as mode, set bit counter to 1, go to ADDR.
REQ-019 ADDR: each mvalid=1 cycle stores swdata into addr[count] and increments count. On storing bit ADDR_WIDTH-1: clear count, go to WDATA if mode=1, else SEND.
REQ-020 WDATA: each mvalid=1 cycle stores swdata into data[count]. On storing bit DATA_WIDTH-1: go to SEND.
REQ-021 mvalid=0 in ADDR or WDATA: stall; no bit captured; counter held; no timeout.
REQ-022 Read transactions: data field SHALL be forced to 0 on entry to SEND.
REQ-023 SEND with u_tx_busy=0: drive u_din={mode,data,addr}, pulse u_en for exactly one cycle. Next state is IDLE if mode=1, else WAIT_RX.
REQ-024 SEND with u_tx_busy=1: hold in SEND; u_en=0.
REQ-025 u_din SHALL hold its last value except when loaded in REQ-023.
REQ-026 prev_rx_ready register SHALL track u_rx_ready every cycle; rising edge = u_rx_ready & !prev_rx_ready.
REQ-027 WAIT_RX on a rising edge: latch u_dout into a shift register, clear count, go to RDATA.
REQ-028 Rising edges in any state other than WAIT_RX SHALL be discarded.
REQ-029 RDATA: for DATA_WIDTH consecutive cycles, svalid=1 and srdata=shift[0], then shift right. After the last bit, return to IDLE with svalid=0 on the following cycle.
REQ-030 svalid and srdata SHALL be 0 outside RDATA.
REQ-031 sready SHALL be 0 in every state except IDLE.
REQ-032 Total write latency: last data bit captured -> u_en asserted the next cycle if u_tx_busy=0.
REQ-033 Only one transaction in flight; no buffering of a second bus request.

Reset
REQ-034 rstn=0: state=IDLE, count=0, addr=0, data=0, mode=0, shift=0, prev_rx_ready=0.
REQ-035 rstn=0 outputs: u_din=0, u_en=0, srdata=0, svalid=0; sready=1 from the first cycle after release.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction; nothing is emitted after release.

Verification
REQ-037 Write: mode=1, addr 0x0A5, data 0x3C shifted in, u_tx_busy=0 -> single u_en pulse with u_din=0x13C0A5, then sready=1 next cycle.
REQ-038 Read: addr 0x123, then u_rx_ready rises with u_dout=0x5A -> u_din=0x000123 when u_en pulses. svalid high 8 cycles with srdata 0,1,0,1,1,0,1,0.
REQ-039 Stall: mvalid=0 for 3 cycles after address bit 5 -> final addr unchanged versus an unstalled transfer; sready stays 0 throughout.
REQ-040 TX backpressure: u_tx_busy=1 for 10 cycles at SEND -> u_en=0 during those cycles; one pulse on the first cycle busy=0.
REQ-041 Spurious RX: u_rx_ready rises while IDLE -> no svalid. A following read completes with its own u_dout.
REQ-042 Reset mid-RDATA after 3 bits: rstn low 2 cycles -> svalid=0 immediately; all REQ-034/035 values hold; no further bits driven.
